// File: rtl/bnn_neuron_array.sv
// Binarized-CNN neuron array: per-lane XNOR-popcount accumulate, max-pool,
// shift-and-threshold normalise and sign activation behind a 3-stage pipeline.
module bnn_neuron_array #(
    parameter int LANES = 32,
    parameter int DW    = 32,
    parameter int AW    = 16,
    parameter int SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [2:0]            cmd,
    input  logic [DW-1:0]         data,
    input  logic [LANES*DW-1:0]   param,
    output logic [LANES-1:0]      activ,
    output logic                  activ_valid
);

    localparam logic [2:0] C_INI  = 3'd0;
    localparam logic [2:0] C_ACC  = 3'd1;
    localparam logic [2:0] C_POOL = 3'd2;
    localparam logic [2:0] C_NORM = 3'd3;
    localparam logic [2:0] C_ACT  = 3'd4;

    // Working width covers both acc+2*DW and the pre-clamp NORM shift.
    localparam int SW = (DW + 2 > AW + SHIFT + 1) ? DW + 2 : AW + SHIFT + 1;

    localparam logic signed [SW-1:0] SAT_HI   = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO   = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0] POOL_MIN = {1'b1, {(AW-1){1'b0}}};

    function automatic logic [SW-1:0] popcnt2(input logic [DW-1:0] w);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < DW; i++) n = n + SW'(w[i]);
        return n << 1;
    endfunction

    function automatic logic signed [AW-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SAT_HI)      return SAT_HI[AW-1:0];
        else if (x < SAT_LO) return SAT_LO[AW-1:0];
        else                 return x[AW-1:0];
    endfunction

    logic          vld_p1, vld_p2;
    logic [2:0]    cmd_p1, cmd_p2;
    logic [DW-1:0] data_p1;

    // Stage 1: accept command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= cmd_valid;
    end

    always_ff @(posedge clk) begin
        if (cmd_valid) begin
            cmd_p1  <= cmd;
            data_p1 <= data;
        end
    end

    // Stage 2: form per-lane operand word with the late-arriving param
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) cmd_p2 <= cmd_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) activ_valid <= 1'b0;
        else     activ_valid <= vld_p2 && (cmd_p2 == C_ACT);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DW-1:0]         prm_g, w_p2;
        logic signed [AW-1:0]  acc, pool, w_lo;
        logic signed [SW-1:0]  acc_sum, norm_val;
        logic                  act_q;

        assign prm_g = param[DW*g +: DW];

        always_ff @(posedge clk) begin
            case (cmd_p1)
                C_INI, C_POOL: w_p2 <= data_p1;
                C_ACC:         w_p2 <= ~(data_p1 ^ prm_g);
                C_NORM:        w_p2 <= prm_g;
                default:       w_p2 <= w_p2;
            endcase
        end

        assign w_lo     = w_p2[AW-1:0];
        assign acc_sum  = {{(SW-AW){acc[AW-1]}}, acc} + popcnt2(w_p2);
        assign norm_val = ({{(SW-AW){pool[AW-1]}}, pool} <<< SHIFT)
                        - {{(SW-AW){w_lo[AW-1]}}, w_lo};

        // Stage 3: lane state update
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc   <= '0;
                pool  <= POOL_MIN;
                act_q <= 1'b0;
            end else if (vld_p2) begin
                case (cmd_p2)
                    C_INI: begin
                        acc  <= w_lo;
                        pool <= POOL_MIN;
                    end
                    C_ACC:  acc <= sat(acc_sum);
                    C_POOL: begin
                        if (acc >= pool) pool <= acc;
                        acc <= w_lo;
                    end
                    C_NORM: pool  <= sat(norm_val);
                    C_ACT:  act_q <= pool[AW-1];
                    default: ;
                endcase
            end
        end

        assign activ[g] = act_q;
    end

endmodule

// File: tb/tb_bnn_neuron_array.sv
// Directed bench for bnn_neuron_array: ACT commands queue a hand-computed
// activation vector and due cycle; a monitor pops and compares on each strobe.
module tb_bnn_neuron_array;
    localparam int LANES = 32;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int SHIFT = 6;

    localparam logic [2:0] INI = 3'd0, ACC = 3'd1, POOL = 3'd2, NORM = 3'd3, ACT = 3'd4;
    localparam logic [31:0] PAT  = 32'h0000_F00D;
    localparam logic [31:0] PAT2 = 32'h8421_3C05;

    typedef logic [LANES*DW-1:0] prm_t;
    typedef struct { logic [LANES-1:0] v; int due; } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic [2:0]           cmd = 3'd7;
    logic [DW-1:0]        data = '0;
    prm_t                 param_drv = '0;
    logic [LANES-1:0]     activ;
    logic                 activ_valid;

    prm_t  prm_next = '0;
    exp_t  sb[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;

    bnn_neuron_array #(.LANES(LANES), .DW(DW), .AW(AW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .data(data),
        .param(param_drv), .activ(activ), .activ_valid(activ_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic prm_t all_lanes(input logic [DW-1:0] w);
        return {LANES{w}};
    endfunction

    function automatic prm_t mask_lanes(input logic [31:0] m, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
        prm_t p;
        for (int g = 0; g < LANES; g++) p[DW*g +: DW] = m[g] ? a : b;
        return p;
    endfunction

    // param trails its command by one cycle
    task automatic issue(input logic [2:0] c, input logic [DW-1:0] d, input prm_t p);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        data      = d;
        param_drv = prm_next;
        prm_next  = p;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd       = ACT;
            data      = $urandom;
            param_drv = prm_next;
            prm_next  = all_lanes('1);
        end
    endtask

    task automatic act(input logic [LANES-1:0] e);
        exp_t x;
        issue(ACT, '0, all_lanes('1));
        x.v   = e;
        x.due = cyc + 3;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [LANES-1:0] got,
                         input logic [LANES-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic window(input logic [DW-1:0] bias, input logic [DW-1:0] d,
                          input prm_t accp, input prm_t normp);
        issue(INI, bias, all_lanes('1));
        issue(ACC, d, accp);
        issue(POOL, '0, all_lanes('1));
        issue(NORM, '0, normp);
    endtask

    always @(negedge clk) begin
        if (!rst && activ_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected activ=%h cyc=%0d", activ, cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (activ !== x.v || cyc != x.due) begin
                    bad++;
                    $display("FAIL strobe activ=%h want=%h cyc=%0d due=%0d", activ, x.v, cyc, x.due);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        prm_t c1;
        c1 = all_lanes('1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_activ", activ, '0);
        check("rst_valid", {31'd0, activ_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // pool resets to most negative
        act('1);
        bubble(5);
        check("activ_hold", activ, '1);

        // async reset while a strobe is on the output
        issue(ACT, '0, c1);
        bubble(1);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", {31'd0, activ_valid}, 32'd1);
        check("pre_rst_activ", activ, '1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_activ", activ, '0);
        check("async_rst_valid", {31'd0, activ_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single window: -32 + 64 = 32, 32*64 - 2048 = 0 / -1
        window(32'hFFFF_FFE0, 32'hFFFF_FFFF, c1, all_lanes(32'h0800));
        act('0);
        window(32'hFFFF_FFE0, 32'hFFFF_FFFF, c1, all_lanes(32'h0801));
        act('1);
        window(32'hFFFF_FFE0, 32'hFFFF_FFFF, c1, mask_lanes(PAT, 32'h0801, 32'h0800));
        act(PAT);
        // lanes with param 0 see no matches: acc -32 -> negative
        window(32'hFFFF_FFE0, 32'hFFFF_FFFF, mask_lanes(PAT2, 32'h0, 32'hFFFF_FFFF),
               all_lanes(32'h0800));
        act(PAT2);

        // max pool over 10, -4, 30, 30 -> 30; 30*64 - 1920 = 0
        issue(INI, 32'd10, c1);
        issue(POOL, 32'hFFFF_FFFC, c1);
        issue(POOL, 32'd30, c1);
        issue(POOL, 32'd30, c1);
        issue(POOL, 32'd0, c1);
        issue(NORM, '0, all_lanes(32'h0780));
        act('0);

        // saturation
        issue(INI, 32'h0000_7FF0, c1);
        issue(ACC, 32'hFFFF_FFFF, c1);
        issue(POOL, '0, c1);
        act('0);
        issue(INI, 32'h0000_8000, c1);
        issue(ACC, 32'h0, c1);
        issue(POOL, '0, c1);
        act('1);
        issue(INI, 32'd1000, c1);
        issue(POOL, '0, c1);
        issue(NORM, '0, all_lanes('0));
        act('0);
        issue(INI, 32'hFFFF_FC18, c1);
        issue(POOL, '0, c1);
        issue(NORM, '0, all_lanes('0));
        act('1);

        // repeated ACC with partial popcount: -64 + 64 + 32 = 32; repeated NORM
        issue(INI, 32'hFFFF_FFC0, c1);
        issue(ACC, 32'hFFFF_FFFF, c1);
        issue(ACC, 32'h0000_FFFF, c1);
        issue(POOL, '0, c1);
        issue(NORM, '0, all_lanes(32'h0800));
        act('0);
        issue(NORM, '0, all_lanes(32'h0001));
        act('1);

        // bubbles and NOPs interleaved, then back-to-back ACTs
        bubble(1);
        issue(INI, 32'hFFFF_FFE0, c1);
        issue(3'd5, 32'h1234_5678, c1);
        bubble(1);
        issue(ACC, 32'hFFFF_FFFF, c1);
        issue(3'd6, 32'h0, c1);
        issue(3'd7, 32'hFFFF_FFFF, c1);
        bubble(2);
        issue(POOL, '0, c1);
        bubble(1);
        issue(NORM, '0, all_lanes(32'h0800));
        bubble(1);
        act('0);
        act('0);
        bubble(4);

        // reset while ACT is in flight: no strobe, state back to reset values
        issue(INI, 32'hFFFF_FFFF, c1);
        issue(POOL, '0, c1);
        act('1);
        bubble(4);
        issue(INI, 32'd5, c1);
        issue(POOL, '0, c1);
        issue(ACT, '0, c1);
        bubble(1);
        #2 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bubble(3);
        check("post_rst_activ", activ, '0);
        act('1);
        issue(POOL, '0, c1);
        act('0);

        bubble(8);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
